// File: rtl/da_idct8_serial.sv
// Bit-serial distributed-arithmetic 8-point 1-D IDCT: one coefficient bit-plane per
// cycle (MSB first), then round-half-up, saturate and hold eight spatial samples.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a coefficient block
// ACC   | one bit-plane per cycle, W_Z cycles, bitcnt counts down to 0
// RND   | round, shift, clip; registers x and sat
// HOLD  | out_valid=1, x/sat stable until out_ready
module da_idct8_serial #(
  parameter int W_Z    = 26,
  parameter int W_O    = 10,
  parameter int OSHIFT = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W_Z-1:0] z0,
  input  logic signed [W_Z-1:0] z1,
  input  logic signed [W_Z-1:0] z2,
  input  logic signed [W_Z-1:0] z3,
  input  logic signed [W_Z-1:0] z4,
  input  logic signed [W_Z-1:0] z5,
  input  logic signed [W_Z-1:0] z6,
  input  logic signed [W_Z-1:0] z7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W_O-1:0] x0,
  output logic signed [W_O-1:0] x1,
  output logic signed [W_O-1:0] x2,
  output logic signed [W_O-1:0] x3,
  output logic signed [W_O-1:0] x4,
  output logic signed [W_O-1:0] x5,
  output logic signed [W_O-1:0] x6,
  output logic signed [W_O-1:0] x7,
  output logic                  sat
);

  localparam int W_A  = W_Z + 16;
  localparam int W_P  = 16;
  localparam int BC_W = $clog2(W_Z);

  localparam logic [BC_W-1:0]       BC_TOP = BC_W'(W_Z - 1);
  localparam logic signed [W_A-1:0] HALF   = W_A'(longint'(1) << (OSHIFT - 1));
  localparam logic signed [W_A-1:0] XMAX   = W_A'((longint'(1) << (W_O - 1)) - 1);
  localparam logic signed [W_A-1:0] XMIN   = W_A'(-(longint'(1) << (W_O - 1)));
  localparam logic signed [W_O-1:0] OMAX   = {1'b0, {(W_O-1){1'b1}}};
  localparam logic signed [W_O-1:0] OMIN   = {1'b1, {(W_O-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, RND, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [W_Z-1:0] zin   [8];
  logic        [W_Z-1:0] zsh   [8];
  logic signed [W_A-1:0] acc   [8];
  logic signed [W_P-1:0] p     [8];
  logic signed [W_A-1:0] rsh   [8];
  logic signed [W_O-1:0] xr    [8];
  logic signed [W_O-1:0] xq    [8];
  logic        [7:0]     clip;
  logic [BC_W-1:0]       bitcnt;
  logic                  first;

  function automatic logic signed [12:0] cval(input int i);
    case (i)
      1:       return 13'sd2008;
      2:       return 13'sd1892;
      3:       return 13'sd1703;
      4:       return 13'sd1448;
      5:       return 13'sd1138;
      6:       return 13'sd783;
      7:       return 13'sd400;
      default: return 13'sd0;
    endcase
  endfunction

  // M[n][k] folded onto the first quarter-wave of the cosine table
  function automatic logic signed [12:0] coef(input int n, input int k);
    int m;
    if (k == 0) return 13'sd1448;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m < 8) return cval(m);
    if (m > 8) return -cval(16 - m);
    return 13'sd0;
  endfunction

  assign zin[0] = z0;
  assign zin[1] = z1;
  assign zin[2] = z2;
  assign zin[3] = z3;
  assign zin[4] = z4;
  assign zin[5] = z5;
  assign zin[6] = z6;
  assign zin[7] = z7;

  assign x0 = xq[0];
  assign x1 = xq[1];
  assign x2 = xq[2];
  assign x3 = xq[3];
  assign x4 = xq[4];
  assign x5 = xq[5];
  assign x6 = xq[6];
  assign x7 = xq[7];

  assign first = (bitcnt == BC_TOP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACC;
      end
      ACC:  if (bitcnt == '0) state_nxt = RND;
      RND:  state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial-product lookup: column sum of M over the set address bits
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      p[n] = '0;
      for (int k = 0; k < 8; k++) begin
        if (zsh[k][W_Z-1]) p[n] = p[n] + W_P'(coef(n, k));
      end
    end
  end

  always_comb begin
    clip = '0;
    for (int n = 0; n < 8; n++) begin
      rsh[n] = (acc[n] + HALF) >>> OSHIFT;
      xr[n]  = rsh[n][W_O-1:0];
      if (rsh[n] > XMAX) begin
        xr[n]   = OMAX;
        clip[n] = 1'b1;
      end else if (rsh[n] < XMIN) begin
        xr[n]   = OMIN;
        clip[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        acc[n] <= '0;
        zsh[n] <= '0;
        xq[n]  <= '0;
      end
      bitcnt <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int n = 0; n < 8; n++) begin
              zsh[n] <= zin[n];
              acc[n] <= '0;
            end
            bitcnt <= BC_TOP;
          end
        end
        ACC: begin
          // MSB plane carries negative two's-complement weight
          for (int n = 0; n < 8; n++) begin
            acc[n] <= (acc[n] <<< 1) + (first ? -W_A'(p[n]) : W_A'(p[n]));
            zsh[n] <= {zsh[n][W_Z-2:0], 1'b0};
          end
          if (bitcnt != '0) bitcnt <= bitcnt - 1'b1;
        end
        RND: begin
          for (int n = 0; n < 8; n++) xq[n] <= xr[n];
          sat <= |clip;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_da_idct8_serial.sv
// Directed self-checking bench for da_idct8_serial: reset, DC, impulse, saturation,
// throughput, backpressure, mid-block reset and a DCT->IDCT round trip.
module tb_da_idct8_serial;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, sat;
  logic signed [25:0] z [8];
  logic signed [9:0]  x [8];
  logic signed [25:0] blk [8];

  int n_cmp = 0;
  int n_err = 0;

  int M [8][8] = '{
    '{1448,  2008,  1892,  1703,  1448,  1138,   783,   400},
    '{1448,  1703,   783,  -400, -1448, -2008, -1892, -1138},
    '{1448,  1138,  -783, -2008, -1448,   400,  1892,  1703},
    '{1448,   400, -1892, -1138,  1448,  1703,  -783, -2008},
    '{1448,  -400, -1892,  1138,  1448, -1703,  -783,  2008},
    '{1448, -1138,  -783,  2008, -1448,  -400,  1892, -1703},
    '{1448, -1703,   783,   400, -1448,  2008, -1892,  1138},
    '{1448, -2008,  1892, -1703,  1448, -1138,   783,  -400}
  };

  int imp_exp [8] = '{126, 106, 71, 25, -25, -71, -106, -125};

  da_idct8_serial dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]),
    .z4(z[4]), .z5(z[5]), .z6(z[6]), .z7(z[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 8; i++) blk[i] = '0;
  endtask

  // Present blk until accepted; afterwards z is driven with junk to show it is not resampled
  task automatic capture();
    int got;
    got = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) z[i] = blk[i];
    for (int i = 0; i < 200 && got == 0; i++) begin
      if (in_ready === 1'b1) got = 1;
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) z[i] = 26'sh0155555;
    chk("accept", got, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      cyc();
      lat++;
    end
    chk("out_valid_rise", out_valid, 1'b1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("consumed_out_valid", out_valid, 1'b0);
    chk("consumed_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_all(input string tag, input int v);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_x%0d", tag, i), x[i], v);
  endtask

  initial begin
    int lat, t, seen, diff;
    int a [8];
    longint acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    clear_blk();
    for (int i = 0; i < 8; i++) z[i] = '0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sat", sat, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    check_all("reset", 0);

    // DC block: DCT of an all-100 input
    clear_blk();
    blk[0] = 26'sd1158400;
    capture();
    wait_out(lat);
    chk("dc_latency", lat, 27);
    check_all("dc", 100);
    chk("dc_sat", sat, 1'b0);
    consume();

    clear_blk();
    blk[1] = 26'sd1048576;
    capture();
    wait_out(lat);
    for (int i = 0; i < 8; i++) chk($sformatf("imp_x%0d", i), x[i], imp_exp[i]);
    chk("imp_sat", sat, 1'b0);
    consume();

    clear_blk();
    blk[0] = 26'sd33554431;
    capture();
    wait_out(lat);
    check_all("satp", 511);
    chk("satp_sat", sat, 1'b1);
    consume();

    clear_blk();
    blk[0] = -26'sd33554432;
    capture();
    wait_out(lat);
    check_all("satn", -512);
    chk("satn_sat", sat, 1'b1);
    consume();

    // Back-to-back blocks with out_ready tied high: period W_Z+3
    clear_blk();
    blk[0] = 26'sd1158400;
    for (int i = 0; i < 8; i++) z[i] = blk[i];
    out_ready = 1'b1;
    in_valid = 1'b1;
    wait_out(lat);
    t = 0;
    do begin
      cyc();
      t++;
    end while (out_valid !== 1'b1 && t < 100);
    in_valid = 1'b0;
    chk("period", t, 29);
    check_all("period", 100);
    cyc();
    out_ready = 1'b0;
    chk("period_idle", in_ready, 1'b1);

    // Backpressure: outputs held, in_valid pulses ignored
    clear_blk();
    blk[1] = 26'sd1048576;
    capture();
    wait_out(lat);
    clear_blk();
    blk[0] = 26'sd33554431;
    for (int i = 0; i < 8; i++) z[i] = blk[i];
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      cyc();
      chk($sformatf("bp%0d_x0", c), x[0], 126);
      chk($sformatf("bp%0d_x7", c), x[7], -125);
      chk($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      chk($sformatf("bp%0d_out_valid", c), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    consume();
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (out_valid === 1'b1) seen = 1;
    end
    chk("bp_no_stray_block", seen, 0);
    chk("bp_x_retained", x[0], 126);

    // Reset in the middle of ACC discards the block
    clear_blk();
    blk[0] = 26'sd1158400;
    capture();
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) seen = 1;
      cyc();
    end
    chk("midrst_no_output", seen, 0);
    chk("midrst_x0", x[0], 0);
    chk("midrst_in_ready", in_ready, 1'b1);
    clear_blk();
    blk[1] = 26'sd1048576;
    capture();
    wait_out(lat);
    for (int i = 0; i < 8; i++) chk($sformatf("post_rst_x%0d", i), x[i], imp_exp[i]);
    consume();

    // Round trip through a forward DCT model, random output backpressure
    for (int b = 0; b < 1000; b++) begin
      for (int n = 0; n < 8; n++) a[n] = int'($urandom_range(1000)) - 500;
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(M[n][k]) * longint'(a[n]);
        blk[k] = 26'(acc);
      end
      capture();
      wait_out(lat);
      repeat ($urandom_range(3)) cyc();
      for (int n = 0; n < 8; n++) begin
        diff = int'(x[n]) - a[n];
        n_cmp++;
        assert ((diff inside {[-1:1]}) === 1'b1) else begin
          n_err++;
          $error("FAIL rt blk%0d x%0d: observed %0d expected %0d +-1", b, n, x[n], a[n]);
        end
      end
      chk($sformatf("rt_sat_blk%0d", b), sat, 1'b0);
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
